// File: rtl/cpu_types_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_types_pkg : shared word, RAM-handshake and bus-controller types  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        WB     = 3'd2,
        SNOOP  = 3'd3,
        C2C    = 3'd4,
        RAMRD  = 3'd5,
        IFETCH = 3'd6
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : picks the first requester strictly after ptr (wrapping) |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    int w_dist;
    int w_best;

    // Distance 0 is the slot right after ptr; ptr itself is the farthest.
    always_comb begin
        grant  = '0;
        valid  = 1'b0;
        w_dist = 0;
        w_best = N;
        for (int j = 0; j < N; j++) begin
            if (req[j]) begin
                w_dist = (j + N - 1 - int'(ptr)) % N;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    grant  = PW'(j);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/snoop_bus_controller.sv
// +----------------------------------------------------------------------+
// | snoop_bus_controller : N-core RAM arbiter with snooped data reads    |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module snoop_bus_controller
    import cpu_types_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [CPUS-1:0]  iREN,
    input  word_t [CPUS-1:0] iaddr,
    output word_t [CPUS-1:0] iload,
    output logic [CPUS-1:0]  iwait,
    input  logic [CPUS-1:0]  dREN,
    input  logic [CPUS-1:0]  dWEN,
    input  word_t [CPUS-1:0] daddr,
    input  word_t [CPUS-1:0] dstore,
    output word_t [CPUS-1:0] dload,
    output logic [CPUS-1:0]  dwait,
    input  logic [CPUS-1:0]  ccwrite,
    output logic [CPUS-1:0]  ccwait,
    output logic [CPUS-1:0]  ccinv,
    output word_t [CPUS-1:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate
);

    localparam int c_ptr_w = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int c_cnt_w = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLOCK_WORDS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_rst = c_ptr_w'(CPUS - 1);

    bus_state_t          r_state, w_nstate;
    logic [c_ptr_w-1:0]  r_grant, w_ngrant;
    logic [c_ptr_w-1:0]  r_sup, w_nsup;
    logic [c_ptr_w-1:0]  r_dptr, w_ndptr;
    logic [c_ptr_w-1:0]  r_iptr, w_niptr;
    logic [c_cnt_w-1:0]  r_count, w_ncount;

    logic [c_ptr_w-1:0]  w_dgrant, w_igrant, w_hit_idx;
    logic                w_dvalid, w_ivalid, w_hit, w_acc, w_last;

    rr_arbiter #(.N(CPUS)) u_darb (
        .req   (dREN | dWEN),
        .ptr   (r_dptr),
        .grant (w_dgrant),
        .valid (w_dvalid)
    );

    rr_arbiter #(.N(CPUS)) u_iarb (
        .req   (iREN),
        .ptr   (r_iptr),
        .grant (w_igrant),
        .valid (w_ivalid)
    );

    assign w_acc  = (ramstate == ACCESS);
    assign w_last = (r_count == c_last);

    // Lowest-numbered peer reporting a dirty hit becomes the supplier.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(r_grant) && ccwrite[j]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_ptr_w'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sup   <= '0;
            r_dptr  <= c_ptr_rst;
            r_iptr  <= c_ptr_rst;
            r_count <= '0;
        end else begin
            r_state <= w_nstate;
            r_grant <= w_ngrant;
            r_sup   <= w_nsup;
            r_dptr  <= w_ndptr;
            r_iptr  <= w_niptr;
            r_count <= w_ncount;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ngrant = r_grant;
        w_nsup   = r_sup;
        w_ndptr  = r_dptr;
        w_niptr  = r_iptr;
        w_ncount = r_count;
        case (r_state)
            IDLE: begin
                if (w_dvalid) begin
                    w_ngrant = w_dgrant;
                    w_ndptr  = w_dgrant;
                    w_nstate = GRANT;
                end else if (w_ivalid) begin
                    w_ngrant = w_igrant;
                    w_niptr  = w_igrant;
                    w_nstate = GRANT;
                end
            end
            GRANT: begin
                if (dWEN[r_grant])      w_nstate = WB;
                else if (dREN[r_grant]) w_nstate = SNOOP;
                else                    w_nstate = IFETCH;
            end
            SNOOP: begin
                if (!dREN[r_grant]) begin
                    w_nstate = IDLE;
                    w_ncount = '0;
                end else if (w_hit) begin
                    w_nsup   = w_hit_idx;
                    w_nstate = C2C;
                end else begin
                    w_nstate = RAMRD;
                end
            end
            WB, C2C, RAMRD: begin
                if ((r_state == WB) ? !dWEN[r_grant] : !dREN[r_grant]) begin
                    w_nstate = IDLE;
                    w_ncount = '0;
                end else if (w_acc) begin
                    if (w_last) begin
                        w_nstate = IDLE;
                        w_ncount = '0;
                    end else begin
                        w_ncount = r_count + c_cnt_w'(1);
                    end
                end
            end
            IFETCH: begin
                if (!iREN[r_grant] || w_acc) w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Every service state is gated by its request so a withdrawn request
    // neither touches the RAM nor releases a wait.
    always_comb begin
        iload       = '0;
        iwait       = '1;
        dload       = '0;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (r_state)
            WB: if (dWEN[r_grant]) begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_grant];
                ramstore = dstore[r_grant];
                if (w_acc) dwait[r_grant] = 1'b0;
            end
            SNOOP, RAMRD: if (dREN[r_grant]) begin
                for (int j = 0; j < CPUS; j++) begin
                    if (j != int'(r_grant)) begin
                        ccwait[j]      = 1'b1;
                        ccsnoopaddr[j] = daddr[r_grant];
                        if (r_state == SNOOP) ccinv[j] = ccwrite[r_grant];
                    end
                end
                if (r_state == RAMRD) begin
                    ramREN         = 1'b1;
                    ramaddr        = daddr[r_grant];
                    dload[r_grant] = ramload;
                    if (w_acc) dwait[r_grant] = 1'b0;
                end
            end
            C2C: if (dREN[r_grant]) begin
                ccwait[r_sup]      = 1'b1;
                ccinv[r_sup]       = ccwrite[r_grant];
                ccsnoopaddr[r_sup] = daddr[r_grant];
                ramWEN             = 1'b1;
                ramaddr            = daddr[r_sup];
                ramstore           = dstore[r_sup];
                dload[r_grant]     = dstore[r_sup];
                if (w_acc) begin
                    dwait[r_grant] = 1'b0;
                    dwait[r_sup]   = 1'b0;
                end
            end
            IFETCH: if (iREN[r_grant]) begin
                ramREN         = 1'b1;
                ramaddr        = iaddr[r_grant];
                iload[r_grant] = ramload;
                if (w_acc) iwait[r_grant] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
// +----------------------------------------------------------------------+
// | tb_snoop_bus_controller : directed bench, 2-core and 4-core instances|
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_snoop_bus_controller;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]  a_iren, a_iwait, a_dren, a_dwen, a_dwait, a_ccwrite, a_ccwait, a_ccinv;
    word_t [1:0] a_iaddr, a_iload, a_daddr, a_dstore, a_dload, a_snaddr;
    logic        a_ramren, a_ramwen;
    word_t       a_ramaddr, a_ramstore, a_ramload;
    ramstate_t   a_ramstate;

    logic [3:0]  b_iren, b_iwait, b_dren, b_dwen, b_dwait, b_ccwrite, b_ccwait, b_ccinv;
    word_t [3:0] b_iaddr, b_iload, b_daddr, b_dstore, b_dload, b_snaddr;
    logic        b_ramren, b_ramwen;
    word_t       b_ramaddr, b_ramstore, b_ramload;
    ramstate_t   b_ramstate;

    snoop_bus_controller #(.CPUS(2), .BLOCK_WORDS(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST),
        .iREN(a_iren), .iaddr(a_iaddr), .iload(a_iload), .iwait(a_iwait),
        .dREN(a_dren), .dWEN(a_dwen), .daddr(a_daddr), .dstore(a_dstore),
        .dload(a_dload), .dwait(a_dwait),
        .ccwrite(a_ccwrite), .ccwait(a_ccwait), .ccinv(a_ccinv), .ccsnoopaddr(a_snaddr),
        .ramREN(a_ramren), .ramWEN(a_ramwen), .ramaddr(a_ramaddr), .ramstore(a_ramstore),
        .ramload(a_ramload), .ramstate(a_ramstate)
    );

    snoop_bus_controller #(.CPUS(4), .BLOCK_WORDS(2)) u_dut4 (
        .CLK(CLK), .nRST(nRST),
        .iREN(b_iren), .iaddr(b_iaddr), .iload(b_iload), .iwait(b_iwait),
        .dREN(b_dren), .dWEN(b_dwen), .daddr(b_daddr), .dstore(b_dstore),
        .dload(b_dload), .dwait(b_dwait),
        .ccwrite(b_ccwrite), .ccwait(b_ccwait), .ccinv(b_ccinv), .ccsnoopaddr(b_snaddr),
        .ramREN(b_ramren), .ramWEN(b_ramwen), .ramaddr(b_ramaddr), .ramstore(b_ramstore),
        .ramload(b_ramload), .ramstate(b_ramstate)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ramstate_t  wb_seq [5];
        int         commits;
        int         pulses;
        logic [3:0] mask;

        a_iren = '0; a_dren = '0; a_dwen = '0; a_ccwrite = '0;
        a_iaddr = '0; a_daddr = '0; a_dstore = '0; a_ramload = '0; a_ramstate = FREE;
        b_iren = '0; b_dren = '0; b_dwen = '0; b_ccwrite = '0;
        b_iaddr = '0; b_daddr = '0; b_dstore = '0; b_ramload = '0; b_ramstate = FREE;

        // Reset values
        #12;
        check("rst_iwait",  a_iwait, 2'b11);
        check("rst_dwait",  a_dwait, 2'b11);
        check("rst_ccwait", a_ccwait, 2'b00);
        check("rst_ccinv",  a_ccinv, 2'b00);
        check("rst_ramren", a_ramren, 1'b0);
        check("rst_ramwen", a_ramwen, 1'b0);
        check("rst_ramaddr", a_ramaddr, 32'h0);
        check("rst_ramstore", a_ramstore, 32'h0);
        check("rst_iload0", a_iload[0], 32'h0);
        check("rst_b_dwait", b_dwait, 4'hF);
        nxt;
        nRST = 1'b1;

        // Instruction fetch, both cores, core 0 first
        a_iren = 2'b11; a_iaddr[0] = 32'h0; a_iaddr[1] = 32'h200;
        a_ramload = 32'h00ABCDEF; a_ramstate = FREE;
        nxt;
        #2 check("if_grant_ren", a_ramren, 1'b0);
        nxt;
        #2 check("if0_ren", a_ramren, 1'b1);
        check("if0_addr", a_ramaddr, 32'h0);
        check("if0_wait_free", a_iwait, 2'b11);
        nxt; a_ramstate = BUSY;
        #2 check("if0_wait_busy", a_iwait, 2'b11);
        nxt;
        nxt; a_ramstate = ACCESS;
        #2 check("if0_iload", a_iload[0], 32'h00ABCDEF);
        check("if0_iwait", a_iwait, 2'b10);
        nxt; a_ramstate = FREE;
        #2 check("if_idle_iwait", a_iwait, 2'b11);
        check("if_idle_ren", a_ramren, 1'b0);
        nxt;
        nxt;
        #2 check("if1_addr", a_ramaddr, 32'h200);
        check("if1_ren", a_ramren, 1'b1);
        a_ramstate = ACCESS;
        #1 check("if1_iwait", a_iwait, 2'b01);
        check("if1_iload", a_iload[1], 32'h00ABCDEF);
        nxt; a_iren = '0; a_ramstate = FREE;

        // Data read beats instruction; clean snoop goes to RAM
        a_dren = 2'b01; a_iren = 2'b10; a_daddr[0] = 32'h100; a_ccwrite = '0;
        nxt;
        nxt;
        #2 check("snp_ccwait", a_ccwait, 2'b10);
        check("snp_addr1", a_snaddr[1], 32'h100);
        check("snp_ren", a_ramren, 1'b0);
        check("snp_iwait", a_iwait, 2'b11);
        nxt; a_ramstate = ACCESS; a_ramload = 32'h00FEDCBA;
        #2 check("rd0_ren", a_ramren, 1'b1);
        check("rd0_wen", a_ramwen, 1'b0);
        check("rd0_addr", a_ramaddr, 32'h100);
        check("rd0_dload", a_dload[0], 32'h00FEDCBA);
        check("rd0_dwait", a_dwait, 2'b10);
        check("rd0_ccwait", a_ccwait, 2'b10);
        nxt; a_daddr[0] = 32'h104; a_ramload = 32'h00EEBBDA;
        #2 check("rd1_dload", a_dload[0], 32'h00EEBBDA);
        check("rd1_dwait", a_dwait, 2'b10);
        check("rd1_addr", a_ramaddr, 32'h104);
        nxt; a_dren = '0; a_iren = '0; a_ramstate = FREE;
        #2 check("rd_idle_dwait", a_dwait, 2'b11);
        check("rd_idle_ren", a_ramren, 1'b0);

        // Cache-to-cache, plain read
        nxt;
        a_dren = 2'b01; a_daddr[0] = 32'h300; a_daddr[1] = 32'h340;
        a_dstore[1] = 32'h1234; a_ccwrite = 2'b10;
        nxt;
        nxt;
        #2 check("c2c_snp_ccinv", a_ccinv, 2'b00);
        check("c2c_snp_ccwait", a_ccwait, 2'b10);
        nxt; a_ramstate = ACCESS;
        #2 check("c2c_wen", a_ramwen, 1'b1);
        check("c2c_ren", a_ramren, 1'b0);
        check("c2c_addr", a_ramaddr, 32'h340);
        check("c2c_store", a_ramstore, 32'h1234);
        check("c2c_dload", a_dload[0], 32'h1234);
        check("c2c_dwait0", a_dwait, 2'b00);
        check("c2c_ccinv", a_ccinv, 2'b00);
        check("c2c_ccwait", a_ccwait, 2'b10);
        nxt;
        #2 check("c2c_dwait1", a_dwait, 2'b00);
        nxt; a_dren = '0; a_ccwrite = '0; a_ramstate = FREE;
        #2 check("c2c_idle_dwait", a_dwait, 2'b11);
        check("c2c_idle_wen", a_ramwen, 1'b0);

        // Cache-to-cache, read-for-ownership
        nxt;
        a_dren = 2'b01; a_ccwrite = 2'b11;
        nxt;
        nxt;
        #2 check("rfo_snp_ccinv", a_ccinv, 2'b10);
        nxt;
        #2 check("rfo_free_ccinv", a_ccinv, 2'b10);
        check("rfo_free_wen", a_ramwen, 1'b1);
        check("rfo_free_dwait", a_dwait, 2'b11);
        nxt; a_ramstate = ACCESS;
        #2 check("rfo_acc_ccinv", a_ccinv, 2'b10);
        check("rfo_acc_dwait", a_dwait, 2'b00);
        nxt;
        #2 check("rfo_acc2_ccinv", a_ccinv, 2'b10);
        nxt; a_dren = '0; a_ccwrite = '0; a_ramstate = FREE;
        #2 check("rfo_idle_ccinv", a_ccinv, 2'b00);

        // Writeback across stalls
        nxt;
        a_dwen = 2'b01; a_daddr[0] = 32'h400; a_dstore[0] = 32'h55;
        wb_seq = '{BUSY, ACCESS, FREE, BUSY, ACCESS};
        commits = 0;
        pulses  = 0;
        nxt;
        nxt;
        for (int k = 0; k < 5; k++) begin
            a_ramstate = wb_seq[k];
            #2 check("wb_wen", a_ramwen, 1'b1);
            if (a_ramwen && a_ramstate == ACCESS) commits++;
            if (!a_dwait[0]) pulses++;
            if (k == 0) begin
                check("wb_addr", a_ramaddr, 32'h400);
                check("wb_store", a_ramstore, 32'h55);
                check("wb_busy_dwait", a_dwait, 2'b11);
            end
            nxt;
        end
        #2 check("wb_commits", commits, 2);
        check("wb_pulses", pulses, 2);
        check("wb_idle_wen", a_ramwen, 1'b0);
        check("wb_idle_dwait", a_dwait, 2'b11);
        a_dwen = '0; a_ramstate = FREE;

        // Asynchronous reset in the middle of a cache-to-cache transfer
        nxt;
        a_dren = 2'b01; a_daddr[0] = 32'h500; a_daddr[1] = 32'h540; a_ccwrite = 2'b10;
        nxt;
        nxt;
        nxt;
        #2 check("arst_pre_wen", a_ramwen, 1'b1);
        nRST = 1'b0;
        #1 check("arst_wen", a_ramwen, 1'b0);
        check("arst_ccwait", a_ccwait, 2'b00);
        check("arst_dwait", a_dwait, 2'b11);
        check("arst_addr", a_ramaddr, 32'h0);
        check("arst_store", a_ramstore, 32'h0);
        check("arst_dload0", a_dload[0], 32'h0);
        nxt;
        nRST = 1'b1; a_dren = 2'b11; a_ccwrite = '0;
        nxt;
        nxt;
        #2 check("arst_next_grant", a_ccwait, 2'b10);
        check("arst_next_snaddr", a_snaddr[1], 32'h500);
        a_dren = '0;
        nxt;
        nxt;

        // Four cores: round-robin order and mid-read withdrawal
        b_dren = 4'hF; b_ramstate = ACCESS; b_ramload = 32'h77;
        for (int k = 0; k < 4; k++) b_daddr[k] = 32'h1000 * (k + 1);
        for (int n = 0; n < 5; n++) begin
            mask = 4'hF & ~(4'b0001 << (n % 4));
            nxt;
            nxt;
            #2 check("rr_ccwait", b_ccwait, mask);
            nxt;
            if (n < 4) begin
                #2 check("rr_dwait", b_dwait, mask);
                check("rr_dload", b_dload[n % 4], 32'h77);
                check("rr_addr", b_ramaddr, 32'h1000 * ((n % 4) + 1));
                nxt;
                nxt;
            end else begin
                b_dren = 4'hE;
                #2 check("wd_dwait", b_dwait, 4'hF);
                check("wd_ren", b_ramren, 1'b0);
                nxt;
                b_dren = 4'hF;
                #2 check("wd_idle_dwait", b_dwait, 4'hF);
                check("wd_idle_ren", b_ramren, 1'b0);
                b_dren = '0;
            end
        end
        nxt;
        nxt;
        nxt;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
